// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_buffered
// 8N1 UART transmitter fed by a byte FIFO; frames leave LSB-first, gapless.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_buffered #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [7:0]                       data_in,
   input  logic                             data_in_valid,
   output logic                             data_in_ready,
   output logic                             serial_out,
   output logic                             tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int CPB    = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W  = $clog2(CPB);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CPB - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------- FIFO
   logic [7:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FCNT_W-1:0] count;
   logic              push;
   logic              pop;
   logic              fifo_nempty;

   assign data_in_ready = (count != FIFO_FULL);
   assign push          = data_in_valid && data_in_ready;
   assign fifo_nempty   = (count != '0);
   assign fifo_count    = count;

   // Storage is written only on accepted bytes, so undriven data never lands here.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ----------------------------------------------------------- framer FSM
   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] baud_cnt_nx;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nx;
   logic [2:0]       bit_idx_inc;
   logic [7:0]       shift;
   logic [7:0]       shift_nx;
   logic             serial_nx;
   logic             baud_done;

   assign baud_done   = (baud_cnt == BAUD_LAST);
   assign bit_idx_inc = bit_idx + 3'd1;
   assign tx_busy     = (state != IDLE) || fifo_nempty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         serial_out <= 1'b1;
      end else begin
         state      <= state_nx;
         baud_cnt   <= baud_cnt_nx;
         bit_idx    <= bit_idx_nx;
         shift      <= shift_nx;
         serial_out <= serial_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      baud_cnt_nx = baud_done ? '0 : baud_cnt + 1'b1;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      serial_nx   = serial_out;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_nx = '0;
            serial_nx   = 1'b1;
            if (fifo_nempty) begin
               pop       = 1'b1;
               shift_nx  = mem[rd_ptr];
               state_nx  = START;
               serial_nx = 1'b0;
            end
         end
         START: begin
            if (baud_done) begin
               state_nx   = DATA;
               bit_idx_nx = '0;
               serial_nx  = shift[0];
            end
         end
         DATA: begin
            if (baud_done) begin
               if (bit_idx == 3'd7) begin
                  state_nx  = STOP;
                  serial_nx = 1'b1;
               end else begin
                  bit_idx_nx = bit_idx_inc;
                  serial_nx  = shift[bit_idx_inc];
               end
            end
         end
         STOP: begin
            // Chaining straight into the next start bit keeps frames gapless.
            if (baud_done) begin
               if (fifo_nempty) begin
                  pop       = 1'b1;
                  shift_nx  = mem[rd_ptr];
                  state_nx  = START;
                  serial_nx = 1'b0;
               end else begin
                  state_nx  = IDLE;
                  serial_nx = 1'b1;
               end
            end
         end
         default: begin
            state_nx  = IDLE;
            serial_nx = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_buffered
// Scoreboard bench for uart_tx_buffered (CPB=5, FIFO_DEPTH=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffered;

   localparam int CPB   = 5;
   localparam int FLEN  = 10 * CPB;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;
   logic       serial_out;
   logic       tx_busy;
   logic [3:0] fifo_count;

   uart_tx_buffered #(
      .CLOCK_FREQ (50_000_000),
      .BAUD_RATE  (10_000_000),
      .FIFO_DEPTH (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .data_in_ready (data_in_ready),
      .serial_out    (serial_out),
      .tx_busy       (tx_busy),
      .fifo_count    (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [7:0] sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Line monitor: decodes frames at mid-bit and pops the scoreboard at the stop bit
   int         ncyc           = 0;
   logic       mon_active     = 1'b0;
   int         mon_cyc        = 0;
   logic [9:0] frame_bits     = '0;
   int         frames_started = 0;
   int         frames_done    = 0;
   int         start_n [64];
   int         busy_fall_n    = 0;
   logic       busy_prev      = 1'b0;

   initial forever begin
      @(negedge clk);
      ncyc++;
      if (busy_prev && !tx_busy) busy_fall_n = ncyc;
      busy_prev = tx_busy;
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (serial_out === 1'b0) begin
            mon_active = 1'b1;
            mon_cyc    = 0;
            if (frames_started < 64) start_n[frames_started] = ncyc;
            frames_started++;
         end
      end else begin
         mon_cyc++;
      end
      if (mon_active && (mon_cyc % CPB) == CPB / 2) begin
         frame_bits[mon_cyc / CPB] = serial_out;
         if (mon_cyc / CPB == 0) check("start_bit", 32'(serial_out), 32'd0);
         if (mon_cyc / CPB == 9) begin
            check("stop_bit", 32'(serial_out), 32'd1);
            if (sb.size() == 0) begin
               check("unexpected_frame", 32'(frame_bits[8:1]), 32'hFFFF_FFFF);
            end else begin
               check("frame_byte", 32'(frame_bits[8:1]), 32'(sb.pop_front()));
            end
            frames_done++;
         end
      end
      if (mon_active && mon_cyc == FLEN - 1) mon_active = 1'b0;
   end

   int   acc_cyc  = 0;
   logic saw_full = 1'b0;

   // Offers one byte until accepted; ready is register-derived so sampling it between edges is safe.
   task automatic push(input logic [7:0] b);
      logic rdy;
      int   n;
      n = 0;
      data_in       = b;
      data_in_valid = 1'b1;
      forever begin
         rdy = data_in_ready;
         if (!rdy) begin
            check("full_count", 32'(fifo_count), 32'd8);
            saw_full = 1'b1;
         end
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 1000) begin
            check("push_timeout", 32'(n), 32'd0);
            break;
         end
      end
      if (rdy) begin
         sb.push_back(b);
         acc_cyc = cyc;
      end
      data_in_valid = 1'b0;
   endtask

   task automatic wait_cycles_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((tx_busy || sb.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drained"}, 32'(sb.size()), 32'd0);
      check({tag, "_idle"}, 32'(tx_busy), 32'd0);
   endtask

   logic [7:0] crlf [7] = '{8'h0D, 8'h0A, 8'h31, 8'h35, 8'h31, 8'h3E, 8'h20};
   logic [7:0] pp   [5] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'h7E};

   initial begin
      int base;
      int fd;
      int a0;
      rst           = 1'b1;
      data_in       = 8'h55;
      data_in_valid = 1'b1;

      // Reset held with valid asserted: nothing accepted, line idle
      repeat (4) begin
         @(negedge clk);
         check("rst_serial", 32'(serial_out), 32'd1);
         check("rst_ready", 32'(data_in_ready), 32'd1);
         check("rst_busy", 32'(tx_busy), 32'd0);
         check("rst_count", 32'(fifo_count), 32'd0);
      end
      @(posedge clk);
      #1;
      rst           = 1'b0;
      data_in_valid = 1'b0;
      @(negedge clk);
      check("post_rst_count", 32'(fifo_count), 32'd0);
      check("post_rst_busy", 32'(tx_busy), 32'd0);

      // Single byte: latency, bit pattern, frame length
      fd = frames_done;
      push(8'h61);
      a0 = acc_cyc;
      check("lat_accept_serial", 32'(serial_out), 32'd1);
      check("lat_accept_count", 32'(fifo_count), 32'd1);
      @(posedge clk);
      #1;
      check("lat_start_serial", 32'(serial_out), 32'd0);
      check("lat_start_count", 32'(fifo_count), 32'd0);
      check("lat_start_busy", 32'(tx_busy), 32'd1);
      wait_cycles_to(a0 + FLEN);
      check("last_cycle_busy", 32'(tx_busy), 32'd1);
      check("last_cycle_serial", 32'(serial_out), 32'd1);
      @(posedge clk);
      #1;
      check("end_busy", 32'(tx_busy), 32'd0);
      check("frame_61_bits", 32'(frame_bits), 32'h2C2);
      check("frame_61_done", 32'(frames_done - fd), 32'd1);

      // Seven back-to-back bytes: gapless frames, 350 cycles total
      repeat (3) @(posedge clk);
      #1;
      base = frames_started;
      foreach (crlf[i]) push(crlf[i]);
      drain("crlf");
      check("crlf_frames", 32'(frames_started - base), 32'd7);
      for (int i = 1; i < 7; i++) begin
         check("crlf_gap", 32'(start_n[base + i] - start_n[base + i - 1]), 32'(FLEN));
      end
      check("crlf_total", 32'(busy_fall_n - start_n[base]), 32'(7 * FLEN));

      // Twelve bytes with valid held: fills FIFO, exercises backpressure and pointer wrap
      @(posedge clk);
      #1;
      saw_full = 1'b0;
      fd       = frames_done;
      for (int i = 0; i < 12; i++) push(8'(i));
      check("saw_full", 32'(saw_full), 32'd1);
      drain("burst");
      check("burst_frames", 32'(frames_done - fd), 32'd12);

      // Reset during data bit 3 of 8'hCA with 3 bytes queued
      @(posedge clk);
      #1;
      push(8'hCA);
      a0 = acc_cyc;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      wait_cycles_to(a0 + 22);
      check("mid_count", 32'(fifo_count), 32'd3);
      check("mid_bit3", 32'(serial_out), 32'd1);
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      rst     = 1'b0;
      data_in = 8'hxx;
      check("abort_serial", 32'(serial_out), 32'd1);
      check("abort_count", 32'(fifo_count), 32'd0);
      check("abort_busy", 32'(tx_busy), 32'd0);
      check("abort_ready", 32'(data_in_ready), 32'd1);
      base = frames_started;
      repeat (60) begin
         @(negedge clk);
         check("abort_line_idle", 32'(serial_out), 32'd1);
      end
      check("abort_no_frame", 32'(frames_started - base), 32'd0);

      // Push coinciding with the STOP->START pop edge at count 3
      @(posedge clk);
      #1;
      fd = frames_done;
      push(pp[0]);
      a0 = acc_cyc;
      push(pp[1]);
      push(pp[2]);
      push(pp[3]);
      wait_cycles_to(a0 + FLEN);
      check("pp_before_count", 32'(fifo_count), 32'd3);
      push(pp[4]);
      check("pp_edge", 32'(acc_cyc - a0), 32'(FLEN + 1));
      check("pp_after_count", 32'(fifo_count), 32'd3);
      check("pp_after_serial", 32'(serial_out), 32'd0);
      drain("pp");
      check("pp_frames", 32'(frames_done - fd), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
